// File: rtl/tap_index_seq.sv
// tap_index_seq: emits linear indices 0..count-1 as (index/3, index%3) plus address
// base + quot*stride + rem. Define TAP_SEQ_PIPE_EN to register quot/rem ahead of the address add.
module tap_index_seq #(
   parameter int IDX_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [IDX_WIDTH-1:0]  i_count,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [ADDR_WIDTH-1:0] i_stride,
   output logic                  o_busy,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [IDX_WIDTH-1:0]  o_quot,
   output logic [1:0]            o_rem,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last,
   output logic                  o_done,
   output logic [1:0]            o_dbg_state
);

   // Handshake: a beat transfers on a rising edge where o_valid and i_ready are both 1;
   // while o_valid=1 and i_ready=0 every beat field holds its value.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

   state_t                state;
   logic [IDX_WIDTH-1:0]  cnt_r;
   logic [ADDR_WIDTH-1:0] stride_r;

   // Generator registers: g_row always equals base + g_quot*stride.
   logic [IDX_WIDTH-1:0]  g_idx;
   logic [IDX_WIDTH-1:0]  g_quot;
   logic [1:0]            g_rem;
   logic [ADDR_WIDTH-1:0] g_row;

   logic [IDX_WIDTH-1:0]  nxt_idx;
   logic [IDX_WIDTH-1:0]  nxt_quot;
   logic [1:0]            nxt_rem;
   logic [ADDR_WIDTH-1:0] nxt_row;
   logic                  nxt_last;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  hs;

`ifdef TAP_SEQ_PIPE_EN
   logic                  s1_valid;
   logic                  g_last;
   logic                  advance;

   assign advance = ~o_valid | i_ready;
`endif

   assign hs          = o_valid & i_ready;
   assign o_dbg_state = state;

   // Incremental divide-by-3: rem wraps 2->0 and carries into quot, row steps by stride.
   always_comb begin
      nxt_idx  = g_idx + IDX_ONE;
      nxt_quot = g_quot;
      nxt_rem  = g_rem + 2'd1;
      nxt_row  = g_row;
      if (g_rem == 2'd2) begin
         nxt_rem  = 2'd0;
         nxt_quot = g_quot + IDX_ONE;
         nxt_row  = g_row + stride_r;
      end
      nxt_last = (nxt_idx == cnt_r - IDX_ONE);
`ifdef TAP_SEQ_PIPE_EN
      out_addr = g_row + ADDR_WIDTH'(g_rem);
`else
      out_addr = nxt_row + ADDR_WIDTH'(nxt_rem);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         o_busy   <= 1'b0;
         o_valid  <= 1'b0;
         o_last   <= 1'b0;
         o_done   <= 1'b0;
         o_quot   <= '0;
         o_rem    <= '0;
         o_addr   <= '0;
         cnt_r    <= '0;
         stride_r <= '0;
         g_idx    <= '0;
         g_quot   <= '0;
         g_rem    <= '0;
         g_row    <= '0;
`ifdef TAP_SEQ_PIPE_EN
         s1_valid <= 1'b0;
         g_last   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  cnt_r    <= i_count;
                  stride_r <= i_stride;
                  g_idx    <= '0;
                  g_quot   <= '0;
                  g_rem    <= '0;
                  g_row    <= i_base;
                  o_busy   <= 1'b1;
                  if (i_count == '0) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     state <= RUN;
`ifdef TAP_SEQ_PIPE_EN
                     s1_valid <= 1'b1;
                     g_last   <= (i_count == IDX_ONE);
`else
                     o_valid <= 1'b1;
                     o_quot  <= '0;
                     o_rem   <= '0;
                     o_addr  <= i_base;
                     o_last  <= (i_count == IDX_ONE);
`endif
                  end
               end
            end

            RUN: begin
`ifdef TAP_SEQ_PIPE_EN
               // Stage 1 moves into the output stage whenever the output slot is free or draining.
               if (advance) begin
                  o_valid <= s1_valid;
                  if (s1_valid) begin
                     o_quot <= g_quot;
                     o_rem  <= g_rem;
                     o_addr <= out_addr;
                     o_last <= g_last;
                     if (g_last) begin
                        s1_valid <= 1'b0;
                     end else begin
                        g_idx  <= nxt_idx;
                        g_quot <= nxt_quot;
                        g_rem  <= nxt_rem;
                        g_row  <= nxt_row;
                        g_last <= nxt_last;
                     end
                  end
               end
`else
               if (hs && !o_last) begin
                  g_idx  <= nxt_idx;
                  g_quot <= nxt_quot;
                  g_rem  <= nxt_rem;
                  g_row  <= nxt_row;
                  o_quot <= nxt_quot;
                  o_rem  <= nxt_rem;
                  o_addr <= out_addr;
                  o_last <= nxt_last;
               end
`endif
               if (hs && o_last) begin
                  state   <= DONE;
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
                  o_done  <= 1'b1;
               end
            end

            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_done <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               o_busy  <= 1'b0;
               o_valid <= 1'b0;
               o_last  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tap_index_seq.sv
// Bench for tap_index_seq: scoreboard of expected beats from an index/3, index%3 model.
// Honours TAP_SEQ_PIPE_EN for first-beat latency.
module tb_tap_index_seq;
   localparam int IW = 8;
   localparam int AW = 16;
   localparam int W  = IW + 2 + AW + 1;
`ifdef TAP_SEQ_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_start = 1'b0;
   logic          i_ready = 1'b0;
   logic [IW-1:0] i_count = '0;
   logic [AW-1:0] i_base = '0;
   logic [AW-1:0] i_stride = '0;
   logic          o_busy, o_valid, o_last, o_done;
   logic [IW-1:0] o_quot;
   logic [1:0]    o_rem;
   logic [AW-1:0] o_addr;
   logic [1:0]    o_dbg_state;

   logic [W-1:0]  exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;

   tap_index_seq #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_count     (i_count),
      .i_base      (i_base),
      .i_stride    (i_stride),
      .o_busy      (o_busy),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_quot      (o_quot),
      .o_rem       (o_rem),
      .o_addr      (o_addr),
      .o_last      (o_last),
      .o_done      (o_done),
      .o_dbg_state (o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_beat(input int idx, input int cnt,
                                               input logic [AW-1:0] base,
                                               input logic [AW-1:0] stride);
      logic [IW-1:0] q;
      logic [1:0]    r;
      logic [AW-1:0] a;
      q = IW'(idx / 3);
      r = 2'(idx % 3);
      a = base + AW'(q) * stride + AW'(r);
      return {q, r, a, (idx == cnt - 1)};
   endfunction

   // Drives one sequence and scores every beat; mode 0: ready=1, 1: ready 1,0,0,1, 2: random.
   task automatic run_seq(input int cnt, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int mode, input string name);
      int           k, last_hs, beats, budget;
      logic         stall_prev;
      logic [W-1:0] held, got, exp;
      for (int i = 0; i < cnt; i++) exp_q.push_back(model_beat(i, cnt, base, stride));
      i_start  = 1'b1;
      i_count  = IW'(cnt);
      i_base   = base;
      i_stride = stride;
      @(posedge clk); #1;
      i_start  = 1'b0;
      i_count  = IW'($urandom_range(1, 255));
      i_base   = AW'($urandom);
      i_stride = AW'($urandom);
      k = 0; last_hs = -1; beats = 0; budget = 4 * cnt + 20;
      stall_prev = 1'b0; held = '0;
      forever begin
         case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: begin
               i_ready = 1'($urandom_range(0, 1));
               i_start = 1'($urandom_range(0, 1));
            end
         endcase
         @(negedge clk);
         got = {o_quot, o_rem, o_addr, o_last};
         check({name, "_busy"}, o_busy, 1);
         if (k < LAT - 1 || cnt == 0) check({name, "_no_valid"}, o_valid, 0);
         if (k == LAT - 1 && cnt != 0) check({name, "_first_valid"}, o_valid, 1);
         if (o_valid && stall_prev) check({name, "_stall_hold"}, got, held);
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check({name, "_extra_beat"}, beats + 1, cnt);
            end else begin
               exp = exp_q.pop_front();
               check({name, "_beat"}, got, exp);
            end
            beats++;
            last_hs = k;
         end
         stall_prev = o_valid && !i_ready;
         held = got;
         if (o_done) begin
            check({name, "_done_time"}, k, (cnt == 0) ? 0 : last_hs + 1);
            break;
         end
         if (k >= budget) begin
            check({name, "_timeout"}, o_done, 1);
            break;
         end
         @(posedge clk); #1;
         k++;
      end
      i_start = 1'b0;
      check({name, "_beats"}, beats, cnt);
      check({name, "_q_empty"}, exp_q.size(), 0);
      if (mode == 0 && cnt > 0) check({name, "_throughput"}, last_hs, LAT - 1 + cnt - 1);
      exp_q.delete();
      @(negedge clk);
      check({name, "_idle"}, {o_busy, o_done, o_valid}, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("reset_outputs", {o_busy, o_valid, o_last, o_done, o_quot, o_rem, o_addr, o_dbg_state}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_seq(7,   16'h0100, 16'h0010, 0, "basic");
      run_seq(7,   16'h0100, 16'h0010, 1, "stall");
      run_seq(0,   16'h0100, 16'h0010, 0, "zero");
      run_seq(2,   16'hFFFF, 16'h0001, 0, "wrap");
      run_seq(255, 16'h1234, 16'h0101, 0, "full");
      run_seq(1,   16'h0042, 16'h0007, 1, "single");
      for (int n = 0; n < 4; n++)
         run_seq($urandom_range(1, 30), AW'($urandom), AW'($urandom), 2, "rand");

      // Reset during the third beat, then restart in the first cycle after release.
      i_start = 1'b1; i_count = IW'(7); i_base = 16'h0100; i_stride = 16'h0010; i_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (o_valid && o_quot == '0 && o_rem == 2'd2) break;
      end
      check("rst_reach_beat3", {o_valid, o_quot, o_rem}, {1'b1, 8'd0, 2'd2});
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_outputs",
            {o_busy, o_valid, o_last, o_done, o_quot, o_rem, o_addr, o_dbg_state}, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_no_done", {o_done, o_valid}, 0);
      end
      rst_n = 1'b1;
      run_seq(5, 16'h0200, 16'h0004, 0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
